mua_frame_tx: RTL and testbench
===============================

Name: mua_frame_tx

Overview:
- Transmit side of the per-sample mua stream: the end that generates the stream `ref_substract` consumes.
- Accepts one frame of per-channel mua samples on a ready/valid write port and buffers it in a ping-pong frame buffer.
- Replays the frame as a contiguous channel-ordered burst on the mua stream (`mua_valid`, `frameNo`, `ch_ref`, `chNo`, `mua_data`, `ch_hash`, `thr_data`).
- `ch_ref` and threshold come from per-channel config tables.

Parameters:
- N_CH, 160: channels per frame, range 2..4095.
- AW, 8: buffer address width; must satisfy 2**AW >= N_CH.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_we  in  1  write strobe for the per-channel config table.
- cfg_addr  in  12  channel written; ignored if >= N_CH.
- cfg_ch_ref  in  12  reference channel for cfg_addr.
- cfg_thr  in  32  threshold for cfg_addr.
- in_valid  in  1  sample-beat valid.
- in_ready  out  1  sample-beat ready.
- in_ch  in  12  channel of the sample.
- in_data  in  32  mua sample value.
- in_frame_no  in  32  frame number; sampled only on the last beat.
- in_last  in  1  marks the final beat of a frame.
- mua_valid  out  1  output beat valid; there is no backpressure.
- frameNo_out  out  32  frame number of the beat.
- ch_ref_out  out  12  reference channel from the config table.
- chNo_out  out  12  channel of the beat.
- mua_data_out  out  32  sample value; 0 if the channel was not written this frame.
- ch_hash_out  out  32  global sample index.
- thr_data_out  out  32  threshold from the config table.
- drop_cnt  out  16  count of discarded beats, saturating.

Behaviour:
- **Reset**
  - All outputs are 0 except in_ready, which is 1.
  - Both banks are free; all bank-valid bits are clear.
  - Config tables are not reset; they hold X until written.
  - The sample counter is 0.
- **Write side**
  - Beat accepted when in_valid && in_ready.
  - If in_ch < N_CH: write in_data to the write bank at in_ch and set valid[in_ch].
  - If in_ch >= N_CH: discard the data and increment drop_cnt, saturating at 0xFFFF. This applies even when in_last=1, and in_last is still honoured.
  - An accepted beat with in_last=1:
    - latch in_frame_no into the bank's frame register;
    - mark the bank full;
    - hand the bank to the reader;
    - the writer switches to the other bank.
  - in_ready = 0 while the writer's target bank is still full or being read. It returns to 1 the cycle after the reader releases that bank.
  - A frame with only in_last (e.g. a single beat) is legal.
  - A duplicate channel within a frame: the last write wins.
- **Read FSM**
  - States: IDLE, RUN, DONE.
  - IDLE -> RUN when a full bank is pending. Banks are read in frame order, oldest first.
  - RUN issues RAM and table reads for addr = 0..N_CH-1, one per cycle.
  - The output register is loaded 2 cycles after each read issue: 1 cycle RAM latency plus 1 cycle output register.
  - Read issue for addr 0 is the cycle after entering RUN. mua_valid for chNo 0 is therefore high 3 cycles after the in_last handshake when the reader was idle.
  - Output burst: N_CH consecutive mua_valid=1 cycles with chNo_out = 0,1,...,N_CH-1.
  - RUN -> DONE after issuing addr N_CH-1.
  - DONE clears the bank's valid bits and full flag, frees the bank, then goes to IDLE. If the other bank is already full, it goes directly to RUN with no idle cycle beyond DONE.
  - Minimum gap between bursts: 1 cycle.
- **Output fields**
  - mua_data_out = valid[ch] ? bank[ch] : 0.
  - frameNo_out is the bank's latched frame number.
  - ch_ref_out and thr_data_out are read from the config tables at issue time. A cfg write to the same address in the same cycle as the read returns the old value.
  - ch_hash_out = running 32-bit sample counter: it is the value before the increment, and increments by 1 per emitted beat, wrapping modulo 2^32. Equivalently, frame index*N_CH+ch from reset.
  - Outside valid beats, the data outputs hold their last value and mua_valid=0.
- **Timing and reset corner cases**
  - Config writes and sample writes are independent and may occur in the same cycle.
  - Asynchronous reset mid-burst:
    - mua_valid drops immediately;
    - the burst is abandoned;
    - both banks are freed;
    - drop_cnt and the sample counter return to 0.

Test Plan:
- **Single frame.** Config ch_ref[k]=k^1 and thr[k]=100+k. Write a frame with in_ch 0..159, in_data=k*3, in_frame_no=7, in_last on ch 159. Required response: 160 contiguous beats starting 3 cycles after the last handshake, with chNo=k, mua=3k, ch_ref=k^1, thr=100+k, frameNo=7, ch_hash=k.
- **Sparse frame.** Write only ch 5 (data 0xAB) and ch 159 (last, frame 2). Required response: mua_data=0 for all channels except ch 5 (0xAB) and ch 159; ch_hash continues from the previous frame (160..319).
- **Ping-pong backpressure.** Write three frames back to back. Required responses:
  - in_ready drops after frame 2's last beat and stays low until frame 1's burst DONE.
  - No beat is lost.
  - Bursts come out in order 1, 2, 3.
- **Out-of-range channel.** Send in_ch=200 with in_last=1. Required response: drop_cnt=1 and the frame is still emitted. Forcing 70000 drops shows drop_cnt=0xFFFF.
- **Reset mid-burst.** Assert rst_n low at beat 40. Required response: mua_valid=0 immediately, in_ready=1, drop_cnt=0. A new frame after release emits from chNo 0 with ch_hash=0.
- **Config collision.** Issue cfg_we for ch 10 (thr=999) in the same cycle as ch 10's read issue. Required response: old thr is output this frame and 999 on the next frame.

Source files
------------

// File: rtl/mua_frame_tx.sv
// ---------------------------------------------------------------------------
// mua_frame_tx
//
// Transmit end of the per-sample mua stream. One frame of per-channel
// samples arrives on a ready/valid write port and is collected in one half
// of a ping-pong frame buffer. A completed frame is then replayed as one
// contiguous, channel-ordered burst of N_CH beats. Each beat carries the
// sample, the frame number, a global sample index, and the reference
// channel and threshold looked up in per-channel configuration tables.
//
// Ports
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   cfg_we/cfg_addr     config table write strobe and channel
//   cfg_ch_ref/cfg_thr  reference channel and threshold for that channel
//   in_valid/in_ready   sample-beat handshake
//   in_ch/in_data       channel and sample value of the beat
//   in_frame_no         frame number, taken from the last beat only
//   in_last             final beat of a frame
//   mua_valid           output beat valid (no backpressure)
//   frameNo_out         frame number of the beat
//   ch_ref_out          reference channel from the config table
//   chNo_out            channel of the beat
//   mua_data_out        sample value, 0 if the channel was not written
//   ch_hash_out         running global sample index
//   thr_data_out        threshold from the config table
//   drop_cnt            saturating count of out-of-range beats
// ---------------------------------------------------------------------------
module mua_frame_tx #(
  parameter int N_CH = 160,
  parameter int AW   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_we,
  input  logic [11:0] cfg_addr,
  input  logic [11:0] cfg_ch_ref,
  input  logic [31:0] cfg_thr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] in_ch,
  input  logic [31:0] in_data,
  input  logic [31:0] in_frame_no,
  input  logic        in_last,
  output logic        mua_valid,
  output logic [31:0] frameNo_out,
  output logic [11:0] ch_ref_out,
  output logic [11:0] chNo_out,
  output logic [31:0] mua_data_out,
  output logic [31:0] ch_hash_out,
  output logic [31:0] thr_data_out,
  output logic [15:0] drop_cnt
);

  localparam int            DEPTH     = 1 << AW;
  localparam logic [11:0]   N_CH_W    = 12'(N_CH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(N_CH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Storage without reset: sample banks and config tables
  logic [31:0] bank_mem_q [0:1][0:DEPTH-1];
  logic [11:0] cfg_ref_mem_q [0:DEPTH-1];
  logic [31:0] cfg_thr_mem_q [0:DEPTH-1];

  // Writer-side state
  logic                  wbank_q;
  logic [1:0]            full_q;
  logic [1:0][DEPTH-1:0] vld_q;
  logic [1:0][31:0]      frame_q;
  logic [15:0]           drop_q;

  // Reader-side state
  state_e        state_q, state_d;
  logic          rbank_q;
  logic [AW-1:0] rd_addr_q;

  // Read pipeline stage 1 (RAM / table output)
  logic        s1_valid_q;
  logic [11:0] s1_ch_q;
  logic [31:0] s1_data_q;
  logic        s1_vbit_q;
  logic [11:0] s1_ref_q;
  logic [31:0] s1_thr_q;
  logic [31:0] s1_frame_q;

  // Output register stage
  logic        out_valid_q;
  logic [31:0] out_frame_q;
  logic [11:0] out_ref_q;
  logic [11:0] out_ch_q;
  logic [31:0] out_data_q;
  logic [31:0] out_hash_q;
  logic [31:0] out_thr_q;
  logic [31:0] cnt_q;

  logic          wr_fire_s;
  logic          in_range_s;
  logic [AW-1:0] wr_addr_s;
  logic          cfg_range_s;
  logic          issue_s;
  logic          done_s;

  assign wr_fire_s   = in_valid & in_ready;
  assign in_range_s  = (in_ch < N_CH_W);
  assign wr_addr_s   = in_ch[AW-1:0];
  assign cfg_range_s = (cfg_addr < N_CH_W);

  // The writer may only fill a bank that the reader has fully released.
  assign in_ready = ~full_q[wbank_q];

  // Sample bank write port
  always_ff @(posedge clk) begin
    if (wr_fire_s && in_range_s) begin
      bank_mem_q[wbank_q][wr_addr_s] <= in_data;
    end
  end

  // Config table write port; same-cycle reads see the previous contents
  always_ff @(posedge clk) begin
    if (cfg_we && cfg_range_s) begin
      cfg_ref_mem_q[cfg_addr[AW-1:0]] <= cfg_ch_ref;
      cfg_thr_mem_q[cfg_addr[AW-1:0]] <= cfg_thr;
    end
  end

  // Writer bookkeeping: bank ownership, valid bits, frame numbers, drops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbank_q <= 1'b0;
      full_q  <= 2'b00;
      vld_q   <= '0;
      frame_q <= '0;
      drop_q  <= 16'd0;
    end else begin
      if (wr_fire_s) begin
        if (in_range_s) begin
          vld_q[wbank_q][wr_addr_s] <= 1'b1;
        end else if (drop_q != 16'hFFFF) begin
          drop_q <= drop_q + 16'd1;
        end
        // in_last closes the frame even on a dropped beat
        if (in_last) begin
          frame_q[wbank_q] <= in_frame_no;
          full_q[wbank_q]  <= 1'b1;
          wbank_q          <= ~wbank_q;
        end
      end
      // The writer never targets the bank being released, so no conflict
      if (done_s) begin
        vld_q[rbank_q]  <= '0;
        full_q[rbank_q] <= 1'b0;
      end
    end
  end

  // Read FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Read FSM next-state and control strobes
  always_comb begin
    state_d = state_q;
    issue_s = 1'b0;
    done_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (full_q[rbank_q]) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        issue_s = 1'b1;
        if (rd_addr_q == LAST_ADDR) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        done_s = 1'b1;
        // Banks alternate, so the other bank always holds the next-oldest frame
        if (full_q[~rbank_q]) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Read address counter and reader bank pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_q <= '0;
      rbank_q   <= 1'b0;
    end else begin
      if (issue_s) begin
        if (rd_addr_q == LAST_ADDR) begin
          rd_addr_q <= '0;
        end else begin
          rd_addr_q <= rd_addr_q + AW'(1);
        end
      end
      if (done_s) begin
        rbank_q <= ~rbank_q;
      end
    end
  end

  // Read stage 1: RAM, valid bit and config table lookups
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_ch_q    <= 12'd0;
      s1_data_q  <= 32'd0;
      s1_vbit_q  <= 1'b0;
      s1_ref_q   <= 12'd0;
      s1_thr_q   <= 32'd0;
      s1_frame_q <= 32'd0;
    end else begin
      s1_valid_q <= issue_s;
      if (issue_s) begin
        s1_ch_q    <= 12'(rd_addr_q);
        s1_data_q  <= bank_mem_q[rbank_q][rd_addr_q];
        s1_vbit_q  <= vld_q[rbank_q][rd_addr_q];
        s1_ref_q   <= cfg_ref_mem_q[rd_addr_q];
        s1_thr_q   <= cfg_thr_mem_q[rd_addr_q];
        s1_frame_q <= frame_q[rbank_q];
      end
    end
  end

  // Output register stage and running sample counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_frame_q <= 32'd0;
      out_ref_q   <= 12'd0;
      out_ch_q    <= 12'd0;
      out_data_q  <= 32'd0;
      out_hash_q  <= 32'd0;
      out_thr_q   <= 32'd0;
      cnt_q       <= 32'd0;
    end else begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_frame_q <= s1_frame_q;
        out_ref_q   <= s1_ref_q;
        out_ch_q    <= s1_ch_q;
        // Channels not written this frame read as zero, not stale data
        out_data_q  <= s1_vbit_q ? s1_data_q : 32'd0;
        out_thr_q   <= s1_thr_q;
        out_hash_q  <= cnt_q;
        cnt_q       <= cnt_q + 32'd1;
      end
    end
  end

  assign mua_valid    = out_valid_q;
  assign frameNo_out  = out_frame_q;
  assign ch_ref_out   = out_ref_q;
  assign chNo_out     = out_ch_q;
  assign mua_data_out = out_data_q;
  assign ch_hash_out  = out_hash_q;
  assign thr_data_out = out_thr_q;
  assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_mua_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_mua_frame_tx
//
// Directed sequence with randomized data for mua_frame_tx. A frame-level
// model (per-channel arrays, config arrays, a queue of expected beats and a
// running sample index) predicts every output beat; a negedge monitor
// compares the stream against it.
// ---------------------------------------------------------------------------
module tb_mua_frame_tx;

  localparam int N_CH = 160;
  localparam int AW   = 8;

  logic        clk;
  logic        rst_n;
  logic        cfg_we;
  logic [11:0] cfg_addr;
  logic [11:0] cfg_ch_ref;
  logic [31:0] cfg_thr;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_ch;
  logic [31:0] in_data;
  logic [31:0] in_frame_no;
  logic        in_last;
  logic        mua_valid;
  logic [31:0] frameNo_out;
  logic [11:0] ch_ref_out;
  logic [11:0] chNo_out;
  logic [31:0] mua_data_out;
  logic [31:0] ch_hash_out;
  logic [31:0] thr_data_out;
  logic [15:0] drop_cnt;

  mua_frame_tx #(.N_CH(N_CH), .AW(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_ch_ref   (cfg_ch_ref),
    .cfg_thr      (cfg_thr),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_ch        (in_ch),
    .in_data      (in_data),
    .in_frame_no  (in_frame_no),
    .in_last      (in_last),
    .mua_valid    (mua_valid),
    .frameNo_out  (frameNo_out),
    .ch_ref_out   (ch_ref_out),
    .chNo_out     (chNo_out),
    .mua_data_out (mua_data_out),
    .ch_hash_out  (ch_hash_out),
    .thr_data_out (thr_data_out),
    .drop_cnt     (drop_cnt)
  );

  typedef struct packed {
    logic [11:0] ch;
    logic [31:0] data;
    logic [11:0] cref;
    logic [31:0] thr;
    logic [31:0] fno;
  } beat_t;

  int          n_checks = 0;
  int          n_err    = 0;
  beat_t       exp_q[$];
  beat_t       m_e;
  logic [31:0] m_hash;
  int          m_bi;
  int          m_drop;
  logic [11:0] m_ref [N_CH];
  logic [31:0] m_thr [N_CH];
  logic [31:0] cur_d [N_CH];
  logic        cur_w [N_CH];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Close the current model frame: one expected beat per channel
  task automatic push_frame(input logic [31:0] fno);
    for (int k = 0; k < N_CH; k++) begin
      beat_t b;
      b.ch   = 12'(k);
      b.data = cur_w[k] ? cur_d[k] : 32'd0;
      b.cref = m_ref[k];
      b.thr  = m_thr[k];
      b.fno  = fno;
      exp_q.push_back(b);
      cur_w[k] = 1'b0;
    end
  endtask

  task automatic cfg_write(input int a, input logic [11:0] r, input logic [31:0] t);
    cfg_we = 1'b1; cfg_addr = 12'(a); cfg_ch_ref = r; cfg_thr = t;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    if (a < N_CH) begin
      m_ref[a] = r;
      m_thr[a] = t;
    end
  endtask

  // One beat; returns 1 ns after the edge that accepted it
  task automatic send(input int ch, input logic [31:0] d, input logic [31:0] fno, input bit last);
    int guard = 0;
    in_valid = 1'b1; in_ch = 12'(ch); in_data = d; in_frame_no = fno; in_last = last;
    while (!in_ready && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 2000) chk("ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    if (ch < N_CH) begin
      cur_d[ch] = d;
      cur_w[ch] = 1'b1;
    end else begin
      m_drop = (m_drop >= 65535) ? 65535 : m_drop + 1;
    end
    if (last) push_frame(fno);
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 3000) begin
      @(posedge clk);
      guard++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Stream monitor: every valid beat against the model queue
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_hash = 32'd0;
      m_bi   = 0;
    end else if (mua_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_beat", 32'(mua_valid), 32'd0);
      end else begin
        m_e = exp_q.pop_front();
        chk("chNo", 32'(chNo_out), 32'(m_e.ch));
        chk("mua_data", mua_data_out, m_e.data);
        chk("ch_ref", 32'(ch_ref_out), 32'(m_e.cref));
        chk("thr", thr_data_out, m_e.thr);
        chk("frameNo", frameNo_out, m_e.fno);
        chk("ch_hash", ch_hash_out, m_hash);
        m_hash = m_hash + 32'd1;
        m_bi   = (m_bi + 1 == N_CH) ? 0 : m_bi + 1;
      end
    end else if (m_bi != 0) begin
      chk("burst_gap", 32'(mua_valid), 32'd1);
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] f1;
    int guard;
    clk = 1'b0; rst_n = 1'b0;
    cfg_we = 1'b0; cfg_addr = 12'd0; cfg_ch_ref = 12'd0; cfg_thr = 32'd0;
    in_valid = 1'b0; in_ch = 12'd0; in_data = 32'd0; in_frame_no = 32'd0; in_last = 1'b0;
    m_drop = 0; m_hash = 32'd0; m_bi = 0;
    for (int k = 0; k < N_CH; k++) begin
      cur_w[k] = 1'b0; cur_d[k] = 32'd0; m_ref[k] = 12'd0; m_thr[k] = 32'd0;
    end

    // Reset values
    repeat (3) @(posedge clk); #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mua_valid", 32'(mua_valid), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("rst_ch_hash", ch_hash_out, 32'd0);
    chk("rst_mua_data", mua_data_out, 32'd0);
    chk("rst_frameNo", frameNo_out, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Config tables: ch_ref = k^1, thr = 100+k
    for (int k = 0; k < N_CH; k++) cfg_write(k, 12'(k ^ 1), 32'(100 + k));

    // Single full frame, data 3k, frame 7, with burst latency
    for (int k = 0; k < N_CH; k++) send(k, 32'(3 * k), 32'd7, k == N_CH - 1);
    chk("lat_e0", 32'(mua_valid), 32'd0);
    @(posedge clk); #1; chk("lat_e1", 32'(mua_valid), 32'd0);
    @(posedge clk); #1; chk("lat_e2", 32'(mua_valid), 32'd0);
    @(posedge clk); #1; chk("lat_e3", 32'(mua_valid), 32'd1);
    chk("lat_e3_ch", 32'(chNo_out), 32'd0);
    drain();

    // Sparse frame: ch 5 and ch 159 only
    send(5, 32'h0000_00AB, 32'd2, 1'b0);
    send(N_CH - 1, $urandom, 32'd2, 1'b1);
    drain();

    // Out-of-range channel closing a frame
    send(200, $urandom, 32'd3, 1'b1);
    chk("drop_one", 32'(drop_cnt), 32'(m_drop));
    drain();

    // Ping-pong: long frame, short frame, then a third that must wait
    f1 = $urandom;
    for (int k = 0; k < N_CH - 1; k++) send(k, $urandom, f1, 1'b0);
    send($urandom_range(0, N_CH - 1), $urandom, f1, 1'b0);
    send(N_CH - 1, $urandom, f1, 1'b1);
    for (int i = 0; i < 20; i++) send($urandom_range(0, N_CH - 1), $urandom, f1 + 32'd1, 1'b0);
    send($urandom_range(0, N_CH - 1), $urandom, f1 + 32'd1, 1'b1);
    chk("pp_ready_low", 32'(in_ready), 32'd0);
    guard = 0;
    while (!in_ready && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("pp_rise_valid", 32'(mua_valid), 32'd1);
    chk("pp_rise_ch", 32'(chNo_out), 32'(N_CH - 1));
    chk("pp_rise_frame", frameNo_out, f1);
    @(posedge clk); #1; chk("pp_gap", 32'(mua_valid), 32'd0);
    @(posedge clk); #1; chk("pp_f2_valid", 32'(mua_valid), 32'd1);
    chk("pp_f2_ch", 32'(chNo_out), 32'd0);
    chk("pp_f2_frame", frameNo_out, f1 + 32'd1);
    for (int k = 0; k < N_CH - 1; k++) begin
      if ($urandom_range(0, 1) == 1) send(k, $urandom, f1 + 32'd2, 1'b0);
    end
    send(N_CH - 1, $urandom, f1 + 32'd2, 1'b1);
    drain();

    // Config write colliding with the read of ch 10 (issued 12 edges after handshake)
    send(10, $urandom, 32'd40, 1'b0);
    send(20, $urandom, 32'd40, 1'b1);
    repeat (11) @(posedge clk);
    #1;
    cfg_write(10, m_ref[10], 32'd999);
    drain();
    send(10, $urandom, 32'd41, 1'b1);
    drain();

    // Asynchronous reset in the middle of a burst
    send(0, $urandom, 32'd50, 1'b0);
    send(N_CH - 1, $urandom, 32'd50, 1'b1);
    guard = 0;
    while (!(mua_valid && chNo_out == 12'd40) && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("mid_reach_40", 32'(chNo_out), 32'd40);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(mua_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_drop", 32'(drop_cnt), 32'd0);
    m_drop = 0;
    for (int k = 0; k < N_CH; k++) cur_w[k] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(3, $urandom, 32'd60, 1'b1);
    drain();

    // Drop counter saturation
    in_valid = 1'b1; in_ch = 12'd300; in_last = 1'b0; in_data = $urandom;
    repeat (65533) @(posedge clk);
    #1;
    m_drop = 65533;
    chk("drop_near_sat", 32'(drop_cnt), 32'(m_drop));
    repeat (5) @(posedge clk);
    #1;
    in_valid = 1'b0;
    m_drop = (m_drop + 5 > 65535) ? 65535 : m_drop + 5;
    chk("drop_sat", 32'(drop_cnt), 32'(m_drop));
    chk("sat_no_beats", 32'(mua_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
